execute_cycle: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX control and data bundle produced by the decode stage, applies operand forwarding, and computes the ALU result, branch decision and branch target. It adds a multi-cycle iterative multiplier (MUL, low 32 bits) that stalls the upstream stages while busy. Results are registered into the EX/MEM pipeline register.

---
 rtl/execute_cycle.sv | 138 +++++++++++++
 tb/tb_execute_cycle.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// RV32I execute stage: forwarding muxes, ALU, beq resolution, a 32-step
// shift-add multiplier that stalls upstream, and the EX/MEM pipeline register.
module execute_cycle #(
  parameter logic [2:0] MUL_OP = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  output logic        StallE,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mstate_t;

  mstate_t     state_q;
  logic [31:0] acc_q, mcand_q, mplier_q;
  logic [4:0]  count_q;

  logic [31:0] src_a, fwd_b, src_b, alu_res;
  logic        is_mul;

  assign is_mul = (ALUControlE == MUL_OP);

  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  // While a multiply is in flight the result is only committed in DONE,
  // so exposing acc_q in every state is harmless.
  always_comb begin
    alu_res = 32'd0;
    if (is_mul) begin
      alu_res = acc_q;
    end else begin
      case (ALUControlE)
        3'b000:  alu_res = src_a + src_b;
        3'b001:  alu_res = src_a - src_b;
        3'b010:  alu_res = src_a & src_b;
        3'b011:  alu_res = src_a | src_b;
        3'b100:  alu_res = src_a ^ src_b;
        3'b101:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
        default: alu_res = 32'd0;
      endcase
    end
  end

  assign PCSrcE    = BranchE & (alu_res == 32'd0);
  assign PCTargetE = PCE + Imm_Ext_E;
  assign StallE    = is_mul && (state_q != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (is_mul) begin
          mcand_q  <= src_a;
          mplier_q <= src_b;
          acc_q    <= '0;
          count_q  <= '0;
          state_q  <= BUSY;
        end
        BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 5'd1;
          if (count_q == 5'd31) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (StallE) begin
      // Bubble into MEM; data fields keep their last values.
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= alu_res;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: forwarding, ALU ops, branch, multiplier
// stall length and products, and reset during a multiply.
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        StallE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  int total = 0;
  int fails = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .ResultW(ResultW), .StallE(StallE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a MUL, counts stall cycles (bounded), perturbs the operands
  // mid-flight, and checks that every stalled cycle put a bubble into MEM.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, output int stalls);
    logic bubble_bad;
    bubble_bad  = 1'b0;
    ALUControlE = 3'b111;
    ALUSrcE     = 1'b0;
    ForwardA_E  = 2'b00;
    ForwardB_E  = 2'b00;
    RD1_E       = a;
    RD2_E       = b;
    RegWriteE   = 1'b1;
    RD_E        = 5'd5;
    #1;
    stalls = 0;
    while (StallE && stalls < 100) begin
      stalls++;
      tick();
      if (RegWriteM !== 1'b0) bubble_bad = 1'b1;
      if (stalls == 5) begin
        RD1_E = ~a;
        RD2_E = b + 32'd3;
      end
    end
    check("mul_bubbles", {31'd0, bubble_bad}, 32'd0);
    tick();
  endtask

  initial begin
    int st;
    rst = 1'b1;
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0;
    PCPlus4E = 0; ResultW = 0; RD_E = 0; ForwardA_E = 0; ForwardB_E = 0;
    tick();
    tick();
    check("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
    check("rst_alu", ALUResultM, 32'd0);
    check("rst_stall", {31'd0, StallE}, 32'd0);
    rst = 1'b0;

    // add with ResultW forwarded into A, immediate B
    RD1_E = 5; ForwardA_E = 2'b01; ResultW = 10; ALUSrcE = 1; Imm_Ext_E = 3;
    RegWriteE = 1; RD_E = 5'd3; PCPlus4E = 32'h44;
    tick();
    check("add_fwdW", ALUResultM, 32'd13);
    check("add_rd", {27'd0, RD_M}, 32'd3);
    check("add_pc4", PCPlus4M, 32'h44);
    check("add_regw", {31'd0, RegWriteM}, 32'd1);

    // both operands forwarded from ALUResultM (13 + 13), store data = 13
    ForwardA_E = 2'b10; ForwardB_E = 2'b10; ALUSrcE = 0; MemWriteE = 1; RegWriteE = 0;
    tick();
    check("add_fwdM", ALUResultM, 32'd26);
    check("wdata_fwdM", WriteDataM, 32'd13);
    check("memw", {31'd0, MemWriteM}, 32'd1);
    MemWriteE = 0;

    // select 11 behaves as 00
    ForwardA_E = 2'b11; ForwardB_E = 2'b00; RD1_E = 7; ALUSrcE = 1; Imm_Ext_E = 2;
    tick();
    check("fwd11", ALUResultM, 32'd9);

    // logic ops and the reserved 110 encoding
    ForwardA_E = 0; ALUSrcE = 0; RD1_E = 32'hF0F0; RD2_E = 32'hFF00;
    ALUControlE = 3'b010; tick(); check("and", ALUResultM, 32'hF000);
    ALUControlE = 3'b011; tick(); check("or",  ALUResultM, 32'hFFF0);
    ALUControlE = 3'b100; tick(); check("xor", ALUResultM, 32'h0FF0);
    ALUControlE = 3'b001; tick(); check("sub", ALUResultM, 32'hFFFFF1F0);
    ALUControlE = 3'b110; tick(); check("op110", ALUResultM, 32'd0);

    // branch resolved combinationally
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 32'h1234; RD2_E = 32'h1234;
    PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    check("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check("beq_target", PCTargetE, 32'h120);
    RD1_E = 1;
    #1;
    check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    PCE = 32'hFFFFFFF0;
    #1;
    check("target_wrap", PCTargetE, 32'h10);
    BranchE = 0;
    tick();

    // signed set-less-than
    ALUControlE = 3'b101; RD1_E = 32'hFFFFFFFF; RD2_E = 1;
    tick(); check("slt_neg", ALUResultM, 32'd1);
    RD1_E = 1; RD2_E = 32'hFFFFFFFF;
    tick(); check("slt_swap", ALUResultM, 32'd0);

    // multiplies, the second two back-to-back with the first
    run_mul(32'd7, 32'd6, st);
    check("mul_stalls", st, 32'd33);
    check("mul_7x6", ALUResultM, 32'd42);
    check("mul_rd", {27'd0, RD_M}, 32'd5);
    check("mul_regw", {31'd0, RegWriteM}, 32'd1);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, st);
    check("mul_b2b_stalls", st, 32'd33);
    check("mul_wrap1", ALUResultM, 32'd1);
    run_mul(32'h80000000, 32'd2, st);
    check("mul_wrap0", ALUResultM, 32'd0);

    // reset at C10 of a multiply
    ALUControlE = 3'b111; RD1_E = 3; RD2_E = 4; RegWriteE = 1; RD_E = 5'd9;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    check("rstmul_alu", ALUResultM, 32'd0);
    check("rstmul_rd", {27'd0, RD_M}, 32'd0);
    check("rstmul_pc4", PCPlus4M, 32'd0);
    check("rstmul_wdata", WriteDataM, 32'd0);
    check("rstmul_regw", {31'd0, RegWriteM}, 32'd0);
    rst = 1'b0;
    ALUControlE = 3'b000; RD1_E = 1; ALUSrcE = 1; Imm_Ext_E = 1; RD_E = 5'd2;
    #1;
    check("rstmul_nostall", {31'd0, StallE}, 32'd0);
    tick();
    check("rstmul_nocommit", ALUResultM, 32'd2);
    check("rstmul_rd2", {27'd0, RD_M}, 32'd2);

    // FSM must be back at IDLE with a cleared count
    run_mul(32'd3, 32'd5, st);
    check("post_rst_stalls", st, 32'd33);
    check("post_rst_mul", ALUResultM, 32'd15);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
